// File: rtl/axi_ic_pkg.sv
// Shared definitions for the 4-master AXI interconnect arbiters.
// Master indices are shared with the read arbiter.
package axi_ic_pkg;

  localparam int AXI_NUM_MASTERS = 4;

  localparam logic [1:0] AXI_MASTER_0 = 2'b00;
  localparam logic [1:0] AXI_MASTER_1 = 2'b01;
  localparam logic [1:0] AXI_MASTER_2 = 2'b10;
  localparam logic [1:0] AXI_MASTER_3 = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_XFER = 2'b01,
    W_RESP = 2'b10
  } w_phase_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: the first requester after 'last',
// wrapping, wins.
module rr_pick4
  import axi_ic_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt_idx,
  output logic       any
);

  always_comb begin
    logic       found;
    logic [1:0] cand;
    gnt_idx = AXI_MASTER_0;
    found   = 1'b0;
    cand    = last;
    any     = |req;
    // Offset 4 wraps back onto 'last' itself, so it has lowest priority.
    for (int i = 1; i <= AXI_NUM_MASTERS; i++) begin
      cand = last + 2'(i);
      if (!found && req[cand]) begin
        gnt_idx = cand;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_arbiter_w.sv
// Write-channel arbiter: grants one master the shared AW/W/B path for a whole
// write transaction (AW, W burst to WLAST, B), then rotates round-robin.
module axi_arbiter_w
  import axi_ic_pkg::*;
(
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       s0_AWVALID,
  input  logic       s0_AWREADY,
  input  logic       s0_WVALID,
  input  logic       s0_WREADY,
  input  logic       s0_WLAST,
  input  logic       s0_BVALID,
  input  logic       s0_BREADY,
  input  logic       s1_AWVALID,
  input  logic       s1_AWREADY,
  input  logic       s1_WVALID,
  input  logic       s1_WREADY,
  input  logic       s1_WLAST,
  input  logic       s1_BVALID,
  input  logic       s1_BREADY,
  input  logic       s2_AWVALID,
  input  logic       s2_AWREADY,
  input  logic       s2_WVALID,
  input  logic       s2_WREADY,
  input  logic       s2_WLAST,
  input  logic       s2_BVALID,
  input  logic       s2_BREADY,
  input  logic       s3_AWVALID,
  input  logic       s3_AWREADY,
  input  logic       s3_WVALID,
  input  logic       s3_WREADY,
  input  logic       s3_WLAST,
  input  logic       s3_BVALID,
  input  logic       s3_BREADY,
  output logic       s0_wgrnt,
  output logic       s1_wgrnt,
  output logic       s2_wgrnt,
  output logic       s3_wgrnt,
  output logic [1:0] wgrnt_idx,
  output logic       busy
);

  logic [3:0] awvalid, awready, wvalid, wready, wlast, bvalid, bready;

  assign awvalid = {s3_AWVALID, s2_AWVALID, s1_AWVALID, s0_AWVALID};
  assign awready = {s3_AWREADY, s2_AWREADY, s1_AWREADY, s0_AWREADY};
  assign wvalid  = {s3_WVALID,  s2_WVALID,  s1_WVALID,  s0_WVALID};
  assign wready  = {s3_WREADY,  s2_WREADY,  s1_WREADY,  s0_WREADY};
  assign wlast   = {s3_WLAST,   s2_WLAST,   s1_WLAST,   s0_WLAST};
  assign bvalid  = {s3_BVALID,  s2_BVALID,  s1_BVALID,  s0_BVALID};
  assign bready  = {s3_BREADY,  s2_BREADY,  s1_BREADY,  s0_BREADY};

  w_phase_e   phase_q, phase_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic       own_aw_hs, own_w_last_hs, own_b_hs;
  logic [1:0] pick_last, pick_idx;
  logic       pick_any;

  assign own_aw_hs     = awvalid[owner_q] & awready[owner_q];
  assign own_w_last_hs = wvalid[owner_q] & wready[owner_q] & wlast[owner_q];
  assign own_b_hs      = bvalid[owner_q] & bready[owner_q];

  // A handover in RESP must rotate from the finishing owner, not the old 'last'.
  assign pick_last = (phase_q == W_RESP && own_b_hs) ? owner_q : last_q;

  rr_pick4 u_pick (
    .req     (awvalid),
    .last    (pick_last),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    phase_d   = phase_q;
    owner_d   = owner_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (phase_q)
      W_IDLE: begin
        if (pick_any) begin
          owner_d   = pick_idx;
          phase_d   = W_XFER;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_XFER: begin
        aw_done_d = aw_done_q | own_aw_hs;
        w_done_d  = w_done_q | own_w_last_hs;
        if (aw_done_d && w_done_d) phase_d = W_RESP;
      end
      W_RESP: begin
        if (own_b_hs) begin
          last_d = owner_q;
          if (pick_any) begin
            owner_d   = pick_idx;
            phase_d   = W_XFER;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            phase_d = W_IDLE;
          end
        end
      end
      default: phase_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      phase_q   <= W_IDLE;
      owner_q   <= AXI_MASTER_0;
      last_q    <= AXI_MASTER_3;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign busy      = (phase_q != W_IDLE);
  assign wgrnt_idx = owner_q;
  assign s0_wgrnt  = busy && (owner_q == AXI_MASTER_0);
  assign s1_wgrnt  = busy && (owner_q == AXI_MASTER_1);
  assign s2_wgrnt  = busy && (owner_q == AXI_MASTER_2);
  assign s3_wgrnt  = busy && (owner_q == AXI_MASTER_3);

endmodule

// File: tb/tb_axi_arbiter_w.sv
// Directed bench for axi_arbiter_w: a per-cycle vector table with
// hand-computed grants, followed by hand-written corner sequences.
module tb_axi_arbiter_w;

  logic       ACLK;
  logic       ARESET;
  logic [3:0] aw, awr, wv, wr, wl, bv, br;
  logic [3:0] gr;
  logic [1:0] wgrnt_idx;
  logic       busy;

  int checks;
  int failures;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] aw, awr, wv, wr, wl, bv, br;
    logic [3:0] exp_gr;
    logic [1:0] exp_idx;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  axi_arbiter_w dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .s0_AWVALID (aw[0]),  .s0_AWREADY (awr[0]), .s0_WVALID (wv[0]), .s0_WREADY (wr[0]),
    .s0_WLAST   (wl[0]),  .s0_BVALID  (bv[0]),  .s0_BREADY (br[0]),
    .s1_AWVALID (aw[1]),  .s1_AWREADY (awr[1]), .s1_WVALID (wv[1]), .s1_WREADY (wr[1]),
    .s1_WLAST   (wl[1]),  .s1_BVALID  (bv[1]),  .s1_BREADY (br[1]),
    .s2_AWVALID (aw[2]),  .s2_AWREADY (awr[2]), .s2_WVALID (wv[2]), .s2_WREADY (wr[2]),
    .s2_WLAST   (wl[2]),  .s2_BVALID  (bv[2]),  .s2_BREADY (br[2]),
    .s3_AWVALID (aw[3]),  .s3_AWREADY (awr[3]), .s3_WVALID (wv[3]), .s3_WREADY (wr[3]),
    .s3_WLAST   (wl[3]),  .s3_BVALID  (bv[3]),  .s3_BREADY (br[3]),
    .s0_wgrnt   (gr[0]),
    .s1_wgrnt   (gr[1]),
    .s2_wgrnt   (gr[2]),
    .s3_wgrnt   (gr[3]),
    .wgrnt_idx  (wgrnt_idx),
    .busy       (busy)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input string name, input logic rst,
                              input logic [3:0] a_aw, input logic [3:0] a_awr,
                              input logic [3:0] a_wv, input logic [3:0] a_wr,
                              input logic [3:0] a_wl, input logic [3:0] a_bv,
                              input logic [3:0] a_br, input logic [3:0] e_gr,
                              input logic [1:0] e_idx, input logic e_busy);
    vec_t v;
    v.name = name; v.rst = rst;
    v.aw = a_aw; v.awr = a_awr; v.wv = a_wv; v.wr = a_wr; v.wl = a_wl;
    v.bv = a_bv; v.br = a_br;
    v.exp_gr = e_gr; v.exp_idx = e_idx; v.exp_busy = e_busy;
    return v;
  endfunction

  task automatic apply_stimulus(input logic rst, input logic [3:0] a_aw,
                                input logic [3:0] a_awr, input logic [3:0] a_wv,
                                input logic [3:0] a_wr, input logic [3:0] a_wl,
                                input logic [3:0] a_bv, input logic [3:0] a_br);
    ARESET = rst;
    aw = a_aw; awr = a_awr; wv = a_wv; wr = a_wr; wl = a_wl; bv = a_bv; br = a_br;
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_output(input string name, input logic [3:0] exp_gr,
                              input logic [1:0] exp_idx, input logic exp_busy,
                              input logic chk_idx);
    checks++;
    if (gr !== exp_gr) begin
      failures++;
      $display("[TB] FAIL %s grant got=%b exp=%b", name, gr, exp_gr);
    end
    checks++;
    if (busy !== exp_busy) begin
      failures++;
      $display("[TB] FAIL %s busy got=%b exp=%b", name, busy, exp_busy);
    end
    if (exp_busy || chk_idx) begin
      checks++;
      if (wgrnt_idx !== exp_idx) begin
        failures++;
        $display("[TB] FAIL %s wgrnt_idx got=%0d exp=%0d", name, wgrnt_idx, exp_idx);
      end
    end
  endtask

  initial begin
    int n_cyc;
    checks   = 0;
    failures = 0;

    //              name         rst aw       awr      wv       wr       wl       bv       br       gr       idx busy
    // s2 alone, 4-beat burst, B held off once by BREADY=0
    vecs.push_back(mk("s2_req",   0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 2, 1));
    vecs.push_back(mk("s2_aw_b1", 0, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 2, 1));
    vecs.push_back(mk("s2_b2",    0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 2, 1));
    vecs.push_back(mk("s2_b3",    0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 2, 1));
    vecs.push_back(mk("s2_b4",    0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2, 1));
    vecs.push_back(mk("s2_bnr",   0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 2, 1));
    vecs.push_back(mk("s2_bhs",   0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 2, 0));
    // all four requesting, single-beat writes: rotation 0,1,2,3,0 without gaps
    vecs.push_back(mk("rot_rst",  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk("rot_g0",   0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 1));
    vecs.push_back(mk("rot_x0",   0, 4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 1));
    vecs.push_back(mk("rot_g1",   0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010, 1, 1));
    vecs.push_back(mk("rot_x1",   0, 4'b1111, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 1));
    vecs.push_back(mk("rot_g2",   0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0100, 2, 1));
    vecs.push_back(mk("rot_x2",   0, 4'b1111, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2, 1));
    vecs.push_back(mk("rot_g3",   0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b1000, 3, 1));
    vecs.push_back(mk("rot_x3",   0, 4'b1111, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 3, 1));
    vecs.push_back(mk("rot_g0b",  0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0001, 0, 1));
    vecs.push_back(mk("rot_x0b",  0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 1));
    vecs.push_back(mk("rot_end",  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0, 0));
    // s1 W-before-AW, s3 noise on W and B, premature owner B in XFER
    vecs.push_back(mk("wf_g1",    0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1, 1));
    vecs.push_back(mk("wf_w1",    0, 4'b0010, 4'b0000, 4'b1010, 4'b1010, 4'b1000, 4'b0000, 4'b0000, 4'b0010, 1, 1));
    vecs.push_back(mk("wf_wlast", 0, 4'b0010, 4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b0010, 1, 1));
    vecs.push_back(mk("wf_aw",    0, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 1, 1));
    vecs.push_back(mk("wf_s3b",   0, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 1, 1));
    vecs.push_back(mk("wf_bhs",   0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 1, 0));
    // s0 AW and WLAST together, B delayed 5 cycles, BVALID without BREADY holds
    vecs.push_back(mk("bd_g0",    0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 1));
    vecs.push_back(mk("bd_awwl",  0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 1));
    vecs.push_back(mk("bd_w1",    0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 1));
    vecs.push_back(mk("bd_w2",    0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 1));
    vecs.push_back(mk("bd_w3",    0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 1));
    vecs.push_back(mk("bd_bnr1",  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 0, 1));
    vecs.push_back(mk("bd_bnr2",  0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 0, 1));
    vecs.push_back(mk("bd_bhs",   0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 0, 0));
    // reset while s3 in RESP, then s0/s3 collide: s0 first after reset
    vecs.push_back(mk("rr_g3",    0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 3, 1));
    vecs.push_back(mk("rr_x3",    0, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 3, 1));
    vecs.push_back(mk("rr_rst",   1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 0, 0));
    vecs.push_back(mk("rr_g0",    0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 1));
    // wrap: s3 then s0 then s3 again with both requesting
    vecs.push_back(mk("wr_x0",    0, 4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 1));
    vecs.push_back(mk("wr_g3",    0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1000, 3, 1));
    vecs.push_back(mk("wr_x3",    0, 4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 3, 1));
    vecs.push_back(mk("wr_g0",    0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0001, 0, 1));
    vecs.push_back(mk("wr_x0b",   0, 4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 1));
    vecs.push_back(mk("wr_g3b",   0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1000, 3, 1));

    apply_stimulus(1'b1, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    apply_stimulus(1'b1, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
    check_output("reset", 4'b0000, 2'd0, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst, vecs[i].aw, vecs[i].awr, vecs[i].wv, vecs[i].wr,
                     vecs[i].wl, vecs[i].bv, vecs[i].br);
      check_output(vecs[i].name, vecs[i].exp_gr, vecs[i].exp_idx, vecs[i].exp_busy,
                   vecs[i].rst);
    end

    // s3 owns XFER; it is also the only requester at its B, so it is re-granted directly
    apply_stimulus(1'b0, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
    check_output("self_resp", 4'b1000, 2'd3, 1'b1, 1'b0);
    apply_stimulus(1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
    check_output("self_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);
    // new transaction has not transferred yet, so a stray B must not release
    apply_stimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
    check_output("self_strayb", 4'b1000, 2'd3, 1'b1, 1'b0);
    apply_stimulus(1'b0, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
    check_output("self_x2", 4'b1000, 2'd3, 1'b1, 1'b0);

    ARESET = 1'b0;
    aw = 4'b0000; awr = 4'b0000; wv = 4'b0000; wr = 4'b0000; wl = 4'b0000;
    bv = 4'b1000; br = 4'b1000;
    n_cyc = 0;
    while (busy && n_cyc < 8) begin
      @(posedge ACLK);
      #1;
      n_cyc++;
    end
    bv = 4'b0000; br = 4'b0000;
    checks++;
    if (n_cyc != 1) begin
      failures++;
      $display("[TB] FAIL release_latency got=%0d cycles exp=1", n_cyc);
    end
    check_output("final_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

    apply_stimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check_output("stay_idle", 4'b0000, 2'd3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
